// File: rtl/io_pkg.sv
// Shared keyboard-path definitions: default byte width, PS/2 break prefix and
// the break-filter state encoding.
package io_pkg;

   localparam int DATA_W_DEF = 8;
   localparam logic [7:0] BREAK_CODE = 8'hF0;

   typedef enum logic {
      FILT_IDLE  = 1'b0,
      FILT_BREAK = 1'b1
   } filt_state_t;

endpackage

// File: rtl/keyboard_input_buffer_sync_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector for the byte-valid level.
// An edge is only reported once the input has been seen low after clr.
module sync_edge_detect (
   input  logic clock,
   input  logic clr,
   input  logic async_in,
   output logic rise_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_fill;
   logic r_armed;

   // r_fill marks that r_meta holds a real sample, so a level held high
   // across clr is never mistaken for a fresh edge.
   always_ff @(posedge clock) begin
      if (!clr) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_fill  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_fill <= 1'b1;
         if (r_fill && !r_meta) r_armed <= 1'b1;
      end
   end

   assign rise_pulse = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/keyboard_input_buffer.sv
// Keyboard byte FIFO feeding the CPU INPR/FGI interface with overflow flag.
// Define KBD_BREAK_FILTER_EN to drop PS/2 break sequences (F0 xx) before the FIFO.
//
// state      | meaning
// FILT_IDLE  | normal bytes pushed; BREAK_CODE discarded and moves to FILT_BREAK
// FILT_BREAK | next byte (released key) discarded, back to FILT_IDLE
module keyboard_input_buffer
   import io_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clock,
   input  logic                     clr,
   input  logic [DATA_W-1:0]        keyboard_input_data,
   input  logic                     input_arrived_flag,
   input  logic                     inpr_read,
   input  logic                     ien,
   input  logic                     overflow_clr,
   output logic [DATA_W-1:0]        inpr_data,
   output logic                     fgi,
   output logic                     interrupt_req,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_inpr_data;
   logic              r_fgi;
   logic              r_irq;
   logic              r_overflow;

   logic              w_rise;
   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_wr_en;
   logic              w_drop;
   logic [PTR_W-1:0]  w_rd_ptr_nxt;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [DATA_W-1:0] w_head_nxt;

   sync_edge_detect u_sync (
      .clock      (clock),
      .clr        (clr),
      .async_in   (input_arrived_flag),
      .rise_pulse (w_rise)
   );

`ifdef KBD_BREAK_FILTER_EN
   filt_state_t r_filt;

   always_ff @(posedge clock) begin
      if (!clr) begin
         r_filt <= FILT_IDLE;
      end else if (w_rise) begin
         case (r_filt)
            FILT_IDLE:  if (keyboard_input_data == DATA_W'(BREAK_CODE)) r_filt <= FILT_BREAK;
            FILT_BREAK: r_filt <= FILT_IDLE;
            default:    r_filt <= FILT_IDLE;
         endcase
      end
   end

   assign w_push = w_rise && (r_filt == FILT_IDLE) &&
                   (keyboard_input_data != DATA_W'(BREAK_CODE));
`else
   assign w_push = w_rise;
`endif

   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_pop        = inpr_read & ~w_empty;
   assign w_wr_en      = w_push & (~w_full | w_pop);
   assign w_drop       = w_push & w_full & ~w_pop;
   assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
   assign w_count_nxt  = r_count + CNT_W'(w_wr_en) - CNT_W'(w_pop);

   // Head stays put when the FIFO drains so a stray read leaves INPR intact.
   always_comb begin
      w_head_nxt = r_inpr_data;
      if (w_wr_en && (w_empty || (w_pop && r_count == CNT_W'(1))))
         w_head_nxt = keyboard_input_data;
      else if (w_pop && r_count > CNT_W'(1))
         w_head_nxt = r_mem[w_rd_ptr_nxt];
   end

   always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= keyboard_input_data;
   end

   always_ff @(posedge clock) begin
      if (!clr) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_inpr_data <= '0;
         r_fgi       <= 1'b0;
         r_irq       <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rd_ptr    <= w_rd_ptr_nxt;
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_count     <= w_count_nxt;
         r_inpr_data <= w_head_nxt;
         r_fgi       <= (w_count_nxt != '0);
         r_irq       <= r_fgi & ien;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (overflow_clr)
            r_overflow <= 1'b0;
      end
   end

   assign inpr_data     = r_inpr_data;
   assign fgi           = r_fgi;
   assign interrupt_req = r_irq;
   assign overflow      = r_overflow;
   assign count         = r_count;

endmodule

// File: tb/tb_keyboard_input_buffer.sv
// Directed bench for keyboard_input_buffer (DEPTH=8, DATA_W=8); follows
// KBD_BREAK_FILTER_EN for the break-filter expectations.
module tb_keyboard_input_buffer;

   logic       clock = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] keyboard_input_data = 8'h00;
   logic       input_arrived_flag = 1'b0;
   logic       inpr_read = 1'b0;
   logic       ien = 1'b0;
   logic       overflow_clr = 1'b0;
   logic [7:0] inpr_data;
   logic       fgi;
   logic       interrupt_req;
   logic       overflow;
   logic [3:0] count;

   int n_chk = 0;
   int n_err = 0;

   keyboard_input_buffer #(.DEPTH(8), .DATA_W(8)) dut (
      .clock               (clock),
      .clr                 (clr),
      .keyboard_input_data (keyboard_input_data),
      .input_arrived_flag  (input_arrived_flag),
      .inpr_read           (inpr_read),
      .ien                 (ien),
      .overflow_clr        (overflow_clr),
      .inpr_data           (inpr_data),
      .fgi                 (fgi),
      .interrupt_req       (interrupt_req),
      .overflow            (overflow),
      .count               (count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      keyboard_input_data = d;
      input_arrived_flag  = 1'b1;
      tick(4);
      input_arrived_flag  = 1'b0;
      tick(3);
   endtask

   task automatic rd(input string tag, input logic [7:0] exp);
      chk(tag, 32'(inpr_data), 32'(exp));
      inpr_read = 1'b1;
      tick(1);
      inpr_read = 1'b0;
   endtask

   initial begin
      tick(3);
      clr = 1'b1;
      tick(3);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_fgi", 32'(fgi), 32'd0);
      chk("rst_irq", 32'(interrupt_req), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", 32'(inpr_data), 32'h00);

      // single byte latency and interrupt
      ien = 1'b1;
      keyboard_input_data = 8'h1C;
      input_arrived_flag = 1'b1;
      tick(2);
      chk("lat_fgi_early", 32'(fgi), 32'd0);
      tick(1);
      chk("lat_fgi", 32'(fgi), 32'd1);
      chk("lat_data", 32'(inpr_data), 32'h1C);
      chk("lat_count", 32'(count), 32'd1);
      chk("lat_irq_early", 32'(interrupt_req), 32'd0);
      tick(1);
      chk("lat_irq", 32'(interrupt_req), 32'd1);
      input_arrived_flag = 1'b0;
      tick(3);
      ien = 1'b0;
      tick(1);
      chk("irq_off", 32'(interrupt_req), 32'd0);
      rd("lat_rd", 8'h1C);
      chk("lat_empty_fgi", 32'(fgi), 32'd0);
      chk("lat_empty_cnt", 32'(count), 32'd0);

      // overflow on ninth byte
      for (int i = 1; i <= 9; i++) send(8'(i));
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 8; i++) rd("ovf_rd", 8'(i));
      chk("ovf_drain_fgi", 32'(fgi), 32'd0);
      chk("ovf_drain_cnt", 32'(count), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      // push and pop together while full
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
      chk("full_count", 32'(count), 32'd8);
      keyboard_input_data = 8'h99;
      input_arrived_flag = 1'b1;
      tick(2);
      inpr_read = 1'b1;
      tick(1);
      inpr_read = 1'b0;
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_head", 32'(inpr_data), 32'h11);
      chk("pp_ovf", 32'(overflow), 32'd0);
      tick(1);
      input_arrived_flag = 1'b0;
      tick(3);
      for (int i = 1; i < 8; i++) rd("pp_rd", 8'h10 + 8'(i));
      rd("pp_last", 8'h99);
      chk("pp_empty", 32'(count), 32'd0);

      // read at empty is ignored
      inpr_read = 1'b1;
      tick(1);
      inpr_read = 1'b0;
      chk("er_count", 32'(count), 32'd0);
      chk("er_data", 32'(inpr_data), 32'h99);
      chk("er_fgi", 32'(fgi), 32'd0);
      send(8'h42);
      chk("er_push_cnt", 32'(count), 32'd1);
      rd("er_push_rd", 8'h42);

      // drop in same cycle as overflow_clr keeps the flag
      for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
      send(8'h77);
      chk("oc_pre", 32'(overflow), 32'd1);
      keyboard_input_data = 8'h78;
      input_arrived_flag = 1'b1;
      tick(2);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      chk("oc_same_cycle", 32'(overflow), 32'd1);
      chk("oc_count", 32'(count), 32'd8);
      chk("oc_head", 32'(inpr_data), 32'h20);
      input_arrived_flag = 1'b0;
      tick(3);
      clr = 1'b0;
      tick(1);
      clr = 1'b1;
      chk("oc_clr_cnt", 32'(count), 32'd0);
      chk("oc_clr_ovf", 32'(overflow), 32'd0);
      tick(2);

      // break filter
      send(8'h1C);
      send(8'hF0);
      send(8'h1C);
      send(8'h32);
`ifdef KBD_BREAK_FILTER_EN
      chk("flt_count", 32'(count), 32'd2);
      rd("flt_rd0", 8'h1C);
      rd("flt_rd1", 8'h32);
`else
      chk("flt_count", 32'(count), 32'd4);
      rd("flt_rd0", 8'h1C);
      rd("flt_rd1", 8'hF0);
      rd("flt_rd2", 8'h1C);
      rd("flt_rd3", 8'h32);
`endif
      chk("flt_empty", 32'(count), 32'd0);

      // clr with flag held high
      for (int i = 1; i <= 4; i++) send(8'h60 + 8'(i));
      keyboard_input_data = 8'h65;
      input_arrived_flag = 1'b1;
      tick(3);
      chk("clr_pre_cnt", 32'(count), 32'd5);
      tick(1);
      clr = 1'b0;
      tick(1);
      clr = 1'b1;
      chk("clr_cnt", 32'(count), 32'd0);
      chk("clr_fgi", 32'(fgi), 32'd0);
      chk("clr_ovf", 32'(overflow), 32'd0);
      tick(6);
      chk("clr_nopush_cnt", 32'(count), 32'd0);
      chk("clr_nopush_fgi", 32'(fgi), 32'd0);
      input_arrived_flag = 1'b0;
      tick(3);
      send(8'h55);
      chk("clr_repush_cnt", 32'(count), 32'd1);
      rd("clr_repush_rd", 8'h55);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
